// File: rtl/icache_pkg.sv
// Shared definitions for the I-cache control logic.
//   state_t  : main controller state encoding
//   CACOP_*  : cache-operation codes carried on cacop_code
//   onehot() : 3-bit way index to an 8-bit one-hot vector (covers up to 8 ways)
package icache_pkg;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_LOOKUP      = 3'd1,
    S_REPLACE     = 3'd2,
    S_REFILL      = 3'd3,
    S_DRAIN       = 3'd4,
    S_CACOP       = 3'd5,
    S_EXTRA_READY = 3'd6
  } state_t;

  localparam logic [1:0] CACOP_STORE_TAG = 2'b00;
  localparam logic [1:0] CACOP_IDX_INV   = 2'b01;
  localparam logic [1:0] CACOP_HIT_INV   = 2'b10;
  localparam logic [1:0] CACOP_NOP       = 2'b11;

  function automatic logic [7:0] onehot(input logic [2:0] idx);
    onehot = 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/icache_main_fsm_param.sv
// Parametrised I-cache main controller: lookup, miss refill, uncached fetch
// and CACOP, with early restart and cancel/drain of in-flight misses.
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   valid, cancel, uncache    IF-stage request, flush, uncached attribute
//   cache_hit, hit            lookup result (any-way / one-hot per way)
//   lru_way_sel               one-hot victim way for refills
//   addr_rbuf, exception      buffered request address, exception code
//   cacop_en, cacop_code      cache-operation request
//   r_rdy_AXI, r_valid, r_last  AXI read handshake and beat stream
//   way_visit .. cacop_complete  RAM, buffer, AXI and IF-side controls
module icache_main_fsm_param
  import icache_pkg::*;
#(
  parameter int unsigned WAYS       = 4,
  parameter int unsigned LINE_WORDS = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            valid,
  input  logic            cancel,
  input  logic            uncache,
  input  logic            cache_hit,
  input  logic [WAYS-1:0] hit,
  input  logic [WAYS-1:0] lru_way_sel,
  input  logic [31:0]     addr_rbuf,
  input  logic [6:0]      exception,
  input  logic            cacop_en,
  input  logic [1:0]      cacop_code,
  input  logic            r_rdy_AXI,
  input  logic            r_valid,
  input  logic            r_last,
  output logic [WAYS-1:0] way_visit,
  output logic            mbuf_we,
  output logic            pbuf_we,
  output logic            rbuf_we,
  output logic            rdata_sel,
  output logic            way_sel_en,
  output logic [7:0]      r_length,
  output logic [WAYS-1:0] mem_we,
  output logic [WAYS-1:0] tagv_we,
  output logic            tagv_clear,
  output logic            r_req,
  output logic            r_data_ready,
  output logic            data_valid,
  output logic            early_valid,
  output logic            cache_ready,
  output logic            cacop_ready,
  output logic            cacop_complete
);

  localparam int unsigned WAY_W  = $clog2(WAYS);
  localparam int unsigned BEAT_W = $clog2(LINE_WORDS);

  state_t state, state_n, idle_next;

  logic [BEAT_W-1:0] beat_cnt;
  logic              killed;
  logic              crit_done;

  logic [BEAT_W-1:0] crit_beat;
  logic              crit_beat_now;
  logic [7:0]        idx_oh;
  logic              unused_bits;

  // Uncached fetches are single-beat, so the wanted word is always beat 0.
  assign crit_beat     = uncache ? '0 : addr_rbuf[BEAT_W+1:2];
  assign crit_beat_now = (state == S_REFILL) && r_valid && (beat_cnt == crit_beat);
  assign idx_oh        = onehot(3'(addr_rbuf[WAY_W-1:0]));
  assign unused_bits   = ^{addr_rbuf, idx_oh};

  // Shared by IDLE, hit-in-LOOKUP and EXTRA_READY: CACOP wins over a fetch.
  always_comb begin
    idle_next = S_IDLE;
    if (cacop_en)   idle_next = S_CACOP;
    else if (valid) idle_next = S_LOOKUP;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      beat_cnt  <= '0;
      killed    <= 1'b0;
      crit_done <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_REPLACE: begin
          // A flush here cannot withdraw the request; remember it so the
          // burst is routed to DRAIN once accepted.
          if (cancel)    killed   <= 1'b1;
          if (r_rdy_AXI) beat_cnt <= '0;
        end
        S_REFILL: begin
          if (r_valid)       beat_cnt  <= beat_cnt + 1'b1;
          if (cancel)        killed    <= 1'b1;
          if (crit_beat_now) crit_done <= 1'b1;
        end
        S_DRAIN: begin
          if (r_valid && r_last) killed <= 1'b0;
        end
        S_EXTRA_READY: begin
          killed    <= 1'b0;
          crit_done <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n = S_IDLE;
    case (state)
      S_IDLE: state_n = idle_next;
      S_LOOKUP: begin
        if (exception != '0)          state_n = S_IDLE;
        else if (cancel)              state_n = S_IDLE;
        else if (uncache || !cache_hit) state_n = S_REPLACE;
        else                          state_n = idle_next;
      end
      S_REPLACE: begin
        if (r_rdy_AXI) state_n = (killed || cancel) ? S_DRAIN : S_REFILL;
        else           state_n = S_REPLACE;
      end
      S_REFILL:      state_n = (r_valid && r_last) ? S_EXTRA_READY : S_REFILL;
      S_DRAIN:       state_n = (r_valid && r_last) ? S_IDLE : S_DRAIN;
      S_CACOP:       state_n = (exception != '0) ? S_IDLE : S_EXTRA_READY;
      S_EXTRA_READY: state_n = idle_next;
      default:       state_n = S_IDLE;
    endcase
  end

  always_comb begin
    way_visit      = '0;
    mbuf_we        = 1'b0;
    pbuf_we        = 1'b0;
    rbuf_we        = 1'b0;
    rdata_sel      = 1'b0;
    way_sel_en     = 1'b0;
    r_length       = 8'(LINE_WORDS - 1);
    mem_we         = '0;
    tagv_we        = '0;
    tagv_clear     = 1'b0;
    r_req          = 1'b0;
    r_data_ready   = 1'b0;
    data_valid     = 1'b0;
    early_valid    = 1'b0;
    cache_ready    = 1'b0;
    cacop_ready    = 1'b0;
    cacop_complete = 1'b0;
    case (state)
      S_IDLE: begin
        rbuf_we     = 1'b1;
        cache_ready = 1'b1;
        cacop_ready = 1'b1;
      end
      S_LOOKUP: begin
        if (exception != '0) begin
          data_valid = 1'b1;
        end else if (cancel) begin
          // killed in LOOKUP: nothing leaves the controller
        end else if (uncache || !cache_hit) begin
          rdata_sel = 1'b1;
          pbuf_we   = 1'b1;
          mbuf_we   = 1'b1;
        end else begin
          rdata_sel   = 1'b1;
          pbuf_we     = 1'b1;
          data_valid  = 1'b1;
          rbuf_we     = 1'b1;
          way_sel_en  = 1'b1;
          cache_ready = 1'b1;
          cacop_ready = 1'b1;
          way_visit   = hit;
        end
      end
      S_REPLACE: begin
        r_req = 1'b1;
        if (uncache) r_length = 8'd0;
      end
      S_REFILL: begin
        r_data_ready = 1'b1;
        early_valid  = crit_beat_now && !killed && !cancel && !crit_done;
        // The line is written even when killed so the tags stay coherent.
        if (r_valid && r_last && !uncache) begin
          mem_we     = lru_way_sel;
          tagv_we    = lru_way_sel;
          way_visit  = lru_way_sel;
          way_sel_en = 1'b1;
        end
      end
      S_DRAIN: begin
        r_data_ready = 1'b1;
      end
      S_CACOP: begin
        if (exception != '0) begin
          data_valid = 1'b1;
        end else begin
          case (cacop_code)
            CACOP_STORE_TAG, CACOP_IDX_INV: begin
              tagv_clear = 1'b1;
              tagv_we    = idx_oh[WAYS-1:0];
              data_valid = 1'b1;
            end
            CACOP_HIT_INV: begin
              tagv_clear = 1'b1;
              tagv_we    = hit;
              data_valid = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_EXTRA_READY: begin
        data_valid     = !killed;
        rbuf_we        = 1'b1;
        cache_ready    = 1'b1;
        cacop_ready    = 1'b1;
        cacop_complete = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
